pipe_mem_access: RTL

//  MEM stage of the 5-stage pipelined CPU; the consumer end of the EXE stage outputs.

---
 rtl/pipe_mem_access.sv | 119 +++++++++++
 1 files changed

// File: rtl/pipe_mem_access.sv
// MEM stage of the 5-stage pipeline: runs one req/ack data-memory access per
// load/store, stalls upstream while it is outstanding, and owns the MEM/WB register.
`timescale 1ns/1ps
module pipe_mem_access #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  output logic        mstall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn,
  output logic        bus_err,
  output logic        align_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [7:0]  count;
  logic [31:0] rdata_q;
  logic        mem_op;
  logic        aligned;

  assign mem_op  = mm2reg | mwmem;
  assign aligned = (malu[1:0] == 2'b00);

  // NOTE: mstall is combinational so a load/store freezes upstream in the same
  // cycle it arrives; it is gated by reset so every output reads 0 while reset is high.
  assign mstall = !reset && ((state == IDLE && mem_op && aligned) || state == REQ);

  // NOTE: all state, including the captured read data, is cleared by the async
  // reset; sequential state is only ever written with non-blocking assignments.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      rdata_q    <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wwreg      <= 1'b0;
      wm2reg     <= 1'b0;
      wmo        <= '0;
      walu       <= '0;
      wrn        <= '0;
      bus_err    <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      bus_err   <= 1'b0;
      align_err <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op && aligned) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mwmem;
            dmem_addr  <= {malu[31:2], 2'b00};
            dmem_wdata <= mb;
            count      <= '0;
            state      <= REQ;
          end else begin
            // A misaligned load/store passes through as a squashed bubble.
            wwreg     <= mwreg & ~mem_op;
            wm2reg    <= mm2reg;
            walu      <= malu;
            wrn       <= mrn;
            align_err <= mem_op;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) rdata_q <= dmem_rdata;
            state    <= DONE;
          end else if (count == LAST_CNT) begin
            dmem_req <= 1'b0;
            bus_err  <= 1'b1;
            state    <= ERR;
          end else begin
            count <= count + 8'd1;
          end
        end
        DONE: begin
          wwreg  <= mwreg;
          wm2reg <= mm2reg;
          if (!dmem_we) wmo <= rdata_q;
          walu   <= malu;
          wrn    <= mrn;
          state  <= IDLE;
        end
        ERR: begin
          wwreg  <= 1'b0;
          wm2reg <= mm2reg;
          walu   <= malu;
          wrn    <= mrn;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
